// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters and a
// registered RGB/sync output stage aligned one pixel behind the coordinates.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel,
  input  logic [23:0] colors,
  output logic [9:0]  horzCoord,
  output logic [9:0]  vertCoord,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic        frame_start
);

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [23:0]      rgb_q;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic             active;
  logic             hs_next;
  logic             vs_next;
  logic [23:0]      rgb_next;

  assign tick    = (div_cnt == DIV_LAST);
  assign vga_clk = (div_cnt >= DIV_HALF);
  assign h_wrap  = (h_cnt == H_LAST);
  assign v_wrap  = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Decode uses the pre-increment counters so the registered outputs describe
  // the coordinate the painter was given during the pixel now ending.
  always_comb begin
    active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_next  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_next  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    rgb_next = '0;
    if (active) begin
      rgb_next = pixel ? colors : BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      rgb_q       <= '0;
    end else if (tick) begin
      vga_hs      <= hs_next;
      vga_vs      <= vs_next;
      vga_blank_n <= active;
      rgb_q       <= rgb_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && h_wrap && v_wrap;
    end
  end

  assign horzCoord  = h_cnt;
  assign vertCoord  = v_cnt;
  assign vga_r      = rgb_q[23:16];
  assign vga_g      = rgb_q[15:8];
  assign vga_b      = rgb_q[7:0];
  assign vga_sync_n = 1'b0;

endmodule
